// File: rtl/ysyx_23060201_gpr.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_gpr
// Purpose  : Architectural register file (x0..x31, x0 hardwired to zero) that
//            serves operand read requests from decode over a valid/ready
//            response handshake. A per-register busy scoreboard holds a
//            request until every pending writeback to its sources (RAW) and
//            to its destination (WAW) has retired.
// Ports    :
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   read request handshake from decode
//   ren[1:0]              ren[0] reads rs1, ren[1] reads rs2
//   raddr1, raddr2        source register indices
//   rsv_en, rsv_rd        destination reservation carried with the request
//   rsp_valid/rsp_ready   operand response handshake toward execute
//   rdata1, rdata2        captured operand values
//   wen, waddr, wdata     writeback port (always active, any FSM state)
//   busy                  scoreboard bitmap, one bit per register
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060201_gpr #(
  parameter int NR_REG = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        ren,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [NR_REG-1:0] busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,  state_d;
  logic [1:0]        ren_q,    ren_d;
  logic [ADDR_W-1:0] raddr1_q, raddr1_d;
  logic [ADDR_W-1:0] raddr2_q, raddr2_d;
  logic              rsv_en_q, rsv_en_d;
  logic [ADDR_W-1:0] rsv_rd_q, rsv_rd_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [NR_REG-1:0] busy_q,   busy_d;
  logic [DATA_W-1:0] regs_q [NR_REG];
  logic [DATA_W-1:0] regs_d [NR_REG];

  // --------------------------------------------------------------------------
  // Effective request: in IDLE the request is evaluated straight off the
  // decode inputs so an unobstructed request is answered the next cycle; in
  // WAIT the latched copy is re-evaluated.
  // --------------------------------------------------------------------------
  logic              in_idle;
  logic [1:0]        sel_ren;
  logic [ADDR_W-1:0] sel_raddr1;
  logic [ADDR_W-1:0] sel_raddr2;
  logic              sel_rsv_en;
  logic [ADDR_W-1:0] sel_rsv_rd;

  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    sel_ren    = in_idle ? ren    : ren_q;
    sel_raddr1 = in_idle ? raddr1 : raddr1_q;
    sel_raddr2 = in_idle ? raddr2 : raddr2_q;
    sel_rsv_en = in_idle ? rsv_en : rsv_en_q;
    sel_rsv_rd = in_idle ? rsv_rd : rsv_rd_q;
  end

  // A register is clear to use when it is unused, x0, not reserved, or being
  // written back this very cycle (the write is bypassed into the capture).
  function automatic logic reg_clear(
    input logic              use_it,
    input logic [ADDR_W-1:0] addr,
    input logic [NR_REG-1:0] bsy,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr
  );
    return !use_it || (addr == '0) || !bsy[addr] || (wr_en && (wr_addr == addr));
  endfunction

  logic operands_ready;

  always_comb begin
    operands_ready = reg_clear(sel_ren[0], sel_raddr1, busy_q, wen, waddr)
                  && reg_clear(sel_ren[1], sel_raddr2, busy_q, wen, waddr)
                  && reg_clear(sel_rsv_en, sel_rsv_rd, busy_q, wen, waddr);
  end

  // Operand values as they would be captured this cycle.
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;

  always_comb begin
    opnd1 = '0;
    if (sel_ren[0] && (sel_raddr1 != '0)) begin
      opnd1 = (wen && (waddr == sel_raddr1)) ? wdata : regs_q[sel_raddr1];
    end
    opnd2 = '0;
    if (sel_ren[1] && (sel_raddr2 != '0)) begin
      opnd2 = (wen && (waddr == sel_raddr2)) ? wdata : regs_q[sel_raddr2];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state process
  // --------------------------------------------------------------------------
  logic capture;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (operands_ready) begin
            state_d = ST_RESP;
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (operands_ready) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output process
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
  assign busy   = busy_q;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    ren_d    = ren_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    rsv_en_d = rsv_en_q;
    rsv_rd_d = rsv_rd_q;
    if (in_idle && req_valid) begin
      ren_d    = ren;
      raddr1_d = raddr1;
      raddr2_d = raddr2;
      rsv_en_d = rsv_en;
      rsv_rd_d = rsv_rd;
    end
  end

  // Response data only changes on capture, so it stays stable in RESP even
  // while writebacks update the underlying registers.
  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (capture) begin
      rdata1_d = opnd1;
      rdata2_d = opnd2;
    end
  end

  // Writeback clears the busy bit; a reservation applied afterwards in the
  // same cycle overrides it, so set wins when both target one register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wen && (waddr != '0)) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (capture && sel_rsv_en && (sel_rsv_rd != '0)) begin
      busy_d[sel_rsv_rd] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register and datapath flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ren_q    <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      rsv_en_q <= 1'b0;
      rsv_rd_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      busy_q   <= '0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      rsv_en_q <= rsv_en_d;
      rsv_rd_q <= rsv_rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      busy_q   <= busy_d;
      regs_q   <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_gpr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060201_gpr
// Purpose  : Self-checking bench for ysyx_23060201_gpr. Directed scenarios
//            (bypass, self-reference, WAW, backpressure, reset in WAIT)
//            followed by randomized request/writeback traffic compared
//            against an array-based register/scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060201_gpr;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  ren;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        rsv_en;
  logic [4:0]  rsv_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  ysyx_23060201_gpr #(.NR_REG(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .ren(ren), .raddr1(raddr1), .raddr2(raddr2),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata1(rdata1), .rdata2(rdata2),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural values plus a busy bitmap.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    if (we && a != 5'd0) begin
      m_regs[a] = d;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    step();
    wen = 1'b0;
    model_write(1'b1, a, d);
  endtask

  task automatic send(input logic [1:0] e, input logic [4:0] a1, input logic [4:0] a2,
                      input logic rv, input logic [4:0] rd);
    req_valid = 1'b1; ren = e; raddr1 = a1; raddr2 = a2; rsv_en = rv; rsv_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    check("ready_again", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  r_en;
    logic [4:0]  r1, r2, rd;
    logic        rv;
    logic [31:0] exp1, exp2;
    int          hold;

    rst = 1'b1; req_valid = 1'b0; ren = 2'b00; raddr1 = '0; raddr2 = '0;
    rsv_en = 1'b0; rsv_rd = '0; rsp_ready = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    check("reset_rdata2", rdata2, 32'd0);

    // Basic read, one-cycle latency.
    wb(5'd5, 32'hDEADBEEF);
    send(2'b11, 5'd5, 5'd0, 1'b0, 5'd0);
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_req_ready", {31'd0, req_ready}, 32'd0);
    check("t1_rdata1", rdata1, 32'hDEADBEEF);
    check("t1_rdata2", rdata2, 32'd0);
    finish_rsp();

    // Reserve x7, then a RAW read of x7 waits for its writeback (bypassed).
    send(2'b00, 5'd0, 5'd0, 1'b1, 5'd7);
    check("t2_busy7", busy, 32'h0000_0080);
    finish_rsp();
    send(2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("t2_wait_req_ready", {31'd0, req_ready}, 32'd0);
      if (i < 2) step();
    end
    wb(5'd7, 32'h0000_1234);
    check("t2_bypass_valid", {31'd0, rsp_valid}, 32'd1);
    check("t2_bypass_rdata1", rdata1, 32'h0000_1234);
    check("t2_busy_clear", busy, 32'd0);
    finish_rsp();

    // Self-reference: reading the register being reserved is not blocked.
    wb(5'd3, 32'd9);
    send(2'b01, 5'd3, 5'd0, 1'b1, 5'd3);
    check("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t3_rdata1", rdata1, 32'd9);
    check("t3_busy3", busy, 32'h0000_0008);
    finish_rsp();

    // WAW: x4 reserved, a second reservation of x4 waits for its writeback.
    send(2'b00, 5'd0, 5'd0, 1'b1, 5'd4);
    check("t4_busy34", busy, 32'h0000_0018);
    finish_rsp();
    send(2'b00, 5'd0, 5'd0, 1'b1, 5'd4);
    check("t4_wait_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check("t4_wait_valid2", {31'd0, rsp_valid}, 32'd0);
    check("t4_wait_ready", {31'd0, req_ready}, 32'd0);
    wb(5'd4, 32'h44);
    check("t4_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t4_busy_reset_wins", busy, 32'h0000_0018);
    finish_rsp();
    wb(5'd3, 32'h33);
    wb(5'd4, 32'h44);
    check("t4_busy_released", busy, 32'd0);

    // Backpressure: response held stable despite a write to the read register.
    send(2'b01, 5'd5, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("t5_hold_rdata1", rdata1, 32'hDEADBEEF);
      if (i == 1) begin wen = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D; end
      step();
      wen = 1'b0;
      if (i == 1) model_write(1'b1, 5'd5, 32'hCAFE_F00D);
    end
    check("t5_hold_rdata1_end", rdata1, 32'hDEADBEEF);
    finish_rsp();
    send(2'b01, 5'd5, 5'd0, 1'b0, 5'd0);
    check("t5_new_value", rdata1, 32'hCAFE_F00D);
    finish_rsp();

    // Reset while in WAIT drops everything; x0 writes are ignored.
    send(2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
    finish_rsp();
    send(2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
    check("t6_in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("t6_req_ready", {31'd0, req_ready}, 32'd1);
    check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_busy", busy, 32'd0);
    wb(5'd0, 32'hFF);
    send(2'b11, 5'd0, 5'd5, 1'b0, 5'd0);
    check("t6_x0_zero", rdata1, 32'd0);
    check("t6_x5_cleared", rdata2, 32'd0);
    finish_rsp();

    // Randomized traffic with concurrent writebacks against the model.
    for (int it = 0; it < 60; it++) begin
      r1   = 5'($urandom_range(0, 31));
      r2   = 5'($urandom_range(0, 31));
      rd   = 5'($urandom_range(0, 31));
      r_en = 2'($urandom_range(0, 3));
      rv   = 1'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) waddr = r1;
      else if ($urandom_range(0, 2) == 0) waddr = r2;
      wdata = $urandom;
      exp1 = 32'd0;
      exp2 = 32'd0;
      if (r_en[0] && r1 != 5'd0) exp1 = (wen && waddr == r1) ? wdata : m_regs[r1];
      if (r_en[1] && r2 != 5'd0) exp2 = (wen && waddr == r2) ? wdata : m_regs[r2];
      check("rnd_req_ready", {31'd0, req_ready}, 32'd1);
      send(r_en, r1, r2, rv, rd);
      model_write(wen, waddr, wdata);
      wen = 1'b0;
      if (rv && rd != 5'd0) m_busy[rd] = 1'b1;
      check("rnd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rnd_rdata1", rdata1, exp1);
      check("rnd_rdata2", rdata2, exp2);
      check("rnd_busy", busy, m_busy);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        wen = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
        step();
        model_write(wen, waddr, wdata);
        wen = 1'b0;
        check("rnd_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("rnd_hold_rdata1", rdata1, exp1);
        check("rnd_hold_busy", busy, m_busy);
      end
      finish_rsp();
      if (rd != 5'd0 && m_busy[rd]) wb(rd, $urandom);
      check("rnd_busy_after", busy, m_busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
